fadd_rr_sched: RTL

- Shares one `fadd` adder instance among NREQ independent requesters.
- Arbitration is round-robin, with valid/ready handshakes on every request port and a single tagged response port.
- The combinational `fadd` sits between an operand register and LAT-1 result registers, giving a fixed-latency pipeline with global backpressure.
- Used by the vector/accumulate units so they need no private floating-point adder each.

---
 rtl/fadd_rr_sched.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/fadd_rr_sched.sv
// fadd: combinational IEEE-754 adder for binary32 (N=32) or binary64 (N=64).
// Round-to-nearest-even, subnormals handled, overflow saturates to infinity.
// Any NaN result (NaN operand or inf + -inf) is returned as all-ones.
//   a_i, b_i : operands
//   y_o      : a_i + b_i
module fadd #(
  parameter int unsigned N = 32
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] y_o
);
  localparam int unsigned EW = (N == 64) ? 11 : 8;
  localparam int unsigned MW = N - 1 - EW;
  localparam int unsigned SW = MW + 5;  // carry, hidden, fraction, guard, round, sticky
  localparam int unsigned XW = EW + 2;  // exponent working width

  logic          a_nan, b_nan, a_inf, b_inf, a_big, sl, ss, up;
  logic [EW-1:0] el, es;
  logic [MW-1:0] fl, fs, fr;
  logic [XW-1:0] xl, xs, dx, lz, sh, xr, xf;
  logic [SW-1:0] ml, ms_full, ms, sum, mn;
  logic [MW+1:0] mr;

  always_comb begin
    a_nan = (&a_i[N-2:MW]) & (|a_i[MW-1:0]);
    b_nan = (&b_i[N-2:MW]) & (|b_i[MW-1:0]);
    a_inf = (&a_i[N-2:MW]) & ~(|a_i[MW-1:0]);
    b_inf = (&b_i[N-2:MW]) & ~(|b_i[MW-1:0]);

    // Order by magnitude so the subtraction below never goes negative.
    a_big        = a_i[N-2:0] >= b_i[N-2:0];
    {sl, el, fl} = a_big ? a_i : b_i;
    {ss, es, fs} = a_big ? b_i : a_i;
    xl = (el == '0) ? XW'(1) : XW'(el);
    xs = (es == '0) ? XW'(1) : XW'(es);
    dx = xl - xs;

    ml      = {1'b0, el != '0, fl, 3'b000};
    ms_full = {1'b0, es != '0, fs, 3'b000};
    if (dx >= XW'(SW)) ms = {{(SW-1){1'b0}}, |ms_full};
    else               ms = (ms_full >> dx) | SW'(|(ms_full & ~({SW{1'b1}} << dx)));

    sum = (sl == ss) ? ml + ms : ml - ms;

    lz = XW'(SW - 1);
    for (int unsigned i = 0; i < SW - 1; i++) begin
      if (sum[i]) lz = XW'(SW - 2 - i);
    end

    // Left shift is capped so the exponent never drops below 1; anything still
    // lacking the hidden bit after that is a subnormal result.
    if (sum[SW-1]) begin
      sh = '0;
      mn = (sum >> 1) | SW'(sum[0]);
      xr = xl + XW'(1);
    end else begin
      sh = (lz < xl - XW'(1)) ? lz : xl - XW'(1);
      mn = sum << sh;
      xr = xl - sh;
    end

    up = mn[2] & (mn[1] | mn[0] | mn[3]);
    mr = {1'b0, mn[SW-2:3]} + (MW+2)'(up);
    if (mr[MW+1]) begin
      xf = xr + XW'(1);
      fr = '0;
    end else begin
      xf = mr[MW] ? xr : '0;
      fr = mr[MW-1:0];
    end

    if (xf >= XW'((1 << EW) - 1)) y_o = {sl, {EW{1'b1}}, {MW{1'b0}}};
    else                          y_o = {sl, xf[EW-1:0], fr};
    if (sum == '0) y_o = {sl & ss, {(N-1){1'b0}}};

    if (a_nan || b_nan || (a_inf && b_inf && (a_i[N-1] != b_i[N-1]))) y_o = '1;
    else if (a_inf) y_o = a_i;
    else if (b_inf) y_o = b_i;
  end
endmodule

// fadd_rr_sched: one shared fadd among NREQ requesters, round-robin arbitration,
// fixed LAT-cycle pipeline with global backpressure and a tagged response port.
//   clk, rst            : clock, synchronous active-high reset
//   req_valid/req_ready : per-requester handshake (ready is one-hot or zero)
//   req_a, req_b        : packed operands, requester i at [i*N +: N]
//   rsp_valid/rsp_ready : response handshake
//   rsp_data, rsp_id    : sum and issuing requester index
//   issue_cnt           : accepted-operation count, wraps at 2^16
module fadd_rr_sched #(
  parameter int unsigned N    = 32,
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2,
  parameter int unsigned LAT  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [N-1:0]      rsp_data,
  output logic [IDW-1:0]    rsp_id,
  output logic [15:0]       issue_cnt
);
  localparam int unsigned NS = LAT - 1;  // stages after the operand register

  logic [N-1:0]    a_arr [NREQ];
  logic [N-1:0]    b_arr [NREQ];
  logic            stall, hs;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_id, ptr_q, ptr_d;
  logic [IDW:0]    cand;
  logic [15:0]     cnt_q, cnt_d;
  logic            s1_v_q;
  logic [N-1:0]    s1_a_q, s1_b_q, fadd_y;
  logic [IDW-1:0]  s1_id_q;
  logic            pv_q  [NS];
  logic [N-1:0]    pd_q  [NS];
  logic [IDW-1:0]  pid_q [NS];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign a_arr[g] = req_a[g*N +: N];
    assign b_arr[g] = req_b[g*N +: N];
  end

  assign stall = rsp_valid & ~rsp_ready;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    hs     = 1'b0;
    cand   = '0;
    if (!rst && !stall) begin
      for (int unsigned off = 0; off < NREQ; off++) begin
        cand = {1'b0, ptr_q} + (IDW+1)'(off);
        if (cand >= (IDW+1)'(NREQ)) cand = cand - (IDW+1)'(NREQ);
        if (!hs && req_valid[cand[IDW-1:0]]) begin
          hs                    = 1'b1;
          gnt[cand[IDW-1:0]]    = 1'b1;
          gnt_id                = cand[IDW-1:0];
        end
      end
    end
    ptr_d = ptr_q;
    if (hs) ptr_d = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
    cnt_d = cnt_q + 16'(hs);
  end

  assign req_ready = gnt;

  fadd #(.N(N)) u_fadd (.a_i(s1_a_q), .b_i(s1_b_q), .y_o(fadd_y));

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= '0;
      cnt_q   <= '0;
      s1_v_q  <= 1'b0;
      s1_a_q  <= '0;
      s1_b_q  <= '0;
      s1_id_q <= '0;
      for (int unsigned k = 0; k < NS; k++) begin
        pv_q[k]  <= 1'b0;
        pd_q[k]  <= '0;
        pid_q[k] <= '0;
      end
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      if (!stall) begin
        s1_v_q <= hs;
        if (hs) begin
          s1_a_q  <= a_arr[gnt_id];
          s1_b_q  <= b_arr[gnt_id];
          s1_id_q <= gnt_id;
        end
        pv_q[0]  <= s1_v_q;
        pd_q[0]  <= fadd_y;
        pid_q[0] <= s1_id_q;
        for (int unsigned k = 1; k < NS; k++) begin
          pv_q[k]  <= pv_q[k-1];
          pd_q[k]  <= pd_q[k-1];
          pid_q[k] <= pid_q[k-1];
        end
      end
    end
  end

  assign rsp_valid = pv_q[NS-1];
  assign rsp_data  = pd_q[NS-1];
  assign rsp_id    = pid_q[NS-1];
  assign issue_cnt = cnt_q;
endmodule
